// File: rtl/reg_link_pkg.sv
// rtl/reg_link_pkg.sv - shared opcodes, register addresses and parser state for the register link
package reg_link_pkg;

  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_STATUS = 4'h2;

  localparam logic [3:0] REG_MAPPER   = 4'd0;
  localparam logic [3:0] REG_LAUNCHER = 4'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_HI,
    ST_WR_LO,
    ST_HOLD,
    ST_RD_SEND
  } state_t;

  // Big-endian byte select: index 0 is the most significant byte.
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/reg_writer_if.sv
// rtl/reg_writer_if.sv - MCU byte link, status response and register write bundle
interface reg_writer_if;

  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rx_sof;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic [11:0] wr_reg;
  logic [3:0]  wr_reg_addr;
  logic        wr_reg_changed;
  logic [31:0] status_reg;
  logic [7:0]  err_cnt;

  modport slave (
    input  rx_valid, rx_data, rx_sof, tx_ready, status_reg,
    output rx_ready, tx_valid, tx_data, wr_reg, wr_reg_addr, wr_reg_changed, err_cnt
  );

  modport master (
    output rx_valid, rx_data, rx_sof, tx_ready, status_reg,
    input  rx_ready, tx_valid, tx_data, wr_reg, wr_reg_addr, wr_reg_changed, err_cnt
  );

endinterface

// File: rtl/reg_writer_status_tx.sv
// rtl/reg_writer_status_tx.sv - snapshots the status word and streams it out MSB first
module status_tx
  import reg_link_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kick,
  input  logic [31:0] word,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        done
);

  logic [31:0] snap;
  logic [1:0]  idx;

  // Combinational so the parser can reopen rx_ready on the final handshake edge.
  assign done = tx_valid && tx_ready && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap     <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (kick) begin
      snap     <= word;
      idx      <= 2'd0;
      tx_valid <= 1'b1;
      tx_data  <= word[31:24];
    end else if (tx_valid && tx_ready) begin
      if (idx == 2'd3) begin
        tx_valid <= 1'b0;
      end else begin
        idx     <= idx + 2'd1;
        tx_data <= byte_sel(snap, idx + 2'd1);
      end
    end
  end

endmodule

// File: rtl/reg_writer.sv
// rtl/reg_writer.sv - parses MCU link bytes into toggle-qualified register writes and status reads
module reg_writer
  import reg_link_pkg::*;
#(
  parameter int HOLD_CYCLES = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_writer_if.slave  link
);

  localparam int HCW = $clog2(HOLD_CYCLES + 1);

  state_t         state;
  logic [HCW-1:0] hold_cnt;
  logic [3:0]     addr_q;
  logic [3:0]     hi_q;

  logic       accept;
  logic       is_cmd;
  logic       abort;
  logic       bad_op;
  logic       kick;
  logic       tx_done;
  logic [3:0] opcode;
  logic [1:0] err_inc;

  always_comb begin
    accept  = link.rx_valid && link.rx_ready;
    opcode  = link.rx_data[7:4];
    // SOF forces command decode anywhere rx_ready can be high.
    is_cmd  = accept && ((state == ST_IDLE) || link.rx_sof);
    abort   = accept && link.rx_sof && ((state == ST_WR_HI) || (state == ST_WR_LO));
    bad_op  = is_cmd && (opcode != OP_WRITE) && (opcode != OP_STATUS);
    kick    = is_cmd && (opcode == OP_STATUS);
    err_inc = {1'b0, abort} + {1'b0, bad_op};
  end

  status_tx u_status_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .kick     (kick),
    .word     (link.status_reg),
    .tx_ready (link.tx_ready),
    .tx_valid (link.tx_valid),
    .tx_data  (link.tx_data),
    .done     (tx_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      hold_cnt            <= '0;
      addr_q              <= '0;
      hi_q                <= '0;
      link.rx_ready       <= 1'b1;
      link.wr_reg         <= '0;
      link.wr_reg_addr    <= '0;
      link.wr_reg_changed <= 1'b0;
      link.err_cnt        <= '0;
    end else begin
      if (abort || bad_op) begin
        link.err_cnt <= sat_add8(link.err_cnt, err_inc);
      end

      if (is_cmd) begin
        case (opcode)
          OP_WRITE: begin
            state  <= ST_WR_HI;
            addr_q <= link.rx_data[3:0];
          end
          OP_STATUS: begin
            state         <= ST_RD_SEND;
            link.rx_ready <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end else begin
        case (state)
          ST_WR_HI: begin
            if (accept) begin
              hi_q  <= link.rx_data[3:0];
              state <= ST_WR_LO;
            end
          end
          ST_WR_LO: begin
            if (accept) begin
              link.wr_reg         <= {hi_q, link.rx_data};
              link.wr_reg_addr    <= addr_q;
              link.wr_reg_changed <= ~link.wr_reg_changed;
              link.rx_ready       <= 1'b0;
              hold_cnt            <= '0;
              state               <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (hold_cnt != HCW'(HOLD_CYCLES)) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
            if (hold_cnt == HCW'(HOLD_CYCLES - 1)) begin
              link.rx_ready <= 1'b1;
              state         <= ST_IDLE;
            end
          end
          ST_RD_SEND: begin
            if (tx_done) begin
              link.rx_ready <= 1'b1;
              state         <= ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_writer.sv
// tb/tb_reg_writer.sv - directed self-checking bench for reg_writer
module tb_reg_writer;

  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reg_writer_if bus ();

  reg_writer #(.HOLD_CYCLES(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sof, output int waited);
    logic acc;
    acc    = 1'b0;
    waited = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    bus.rx_sof   = sof;
    while (!acc && waited < 50) begin
      acc = bus.rx_ready;
      tick();
      waited++;
    end
    bus.rx_valid = 1'b0;
    bus.rx_sof   = 1'b0;
    chk("rx_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic write3(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] lo);
    int w;
    send_byte(c, 1'b1, w);
    send_byte(hi, 1'b0, w);
    send_byte(lo, 1'b0, w);
  endtask

  task automatic recv4(input logic [31:0] exp);
    int got;
    int cyc;
    logic v;
    logic r;
    logic [7:0] d;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 40) begin
      bus.tx_ready = cyc[0];
      v = bus.tx_valid;
      r = bus.tx_ready;
      d = bus.tx_data;
      tick();
      cyc++;
      if (v && r) begin
        chk($sformatf("tx_byte%0d", got), {24'b0, d}, {24'b0, exp[31-8*got -: 8]});
        got++;
      end else if (v) begin
        chk("tx_stall_stable", {24'b0, bus.tx_data}, {24'b0, d});
      end
    end
    bus.tx_ready = 1'b0;
    chk("tx_count", got, 32'd4);
    chk("tx_valid_after", {31'b0, bus.tx_valid}, 32'd0);
    chk("rx_ready_after_rd", {31'b0, bus.rx_ready}, 32'd1);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_rx_ready"}, {31'b0, bus.rx_ready}, 32'd1);
    chk({pfx, "_tx_valid"}, {31'b0, bus.tx_valid}, 32'd0);
    chk({pfx, "_tx_data"}, {24'b0, bus.tx_data}, 32'd0);
    chk({pfx, "_wr_reg"}, {20'b0, bus.wr_reg}, 32'd0);
    chk({pfx, "_wr_addr"}, {28'b0, bus.wr_reg_addr}, 32'd0);
    chk({pfx, "_changed"}, {31'b0, bus.wr_reg_changed}, 32'd0);
    chk({pfx, "_err_cnt"}, {24'b0, bus.err_cnt}, 32'd0);
  endtask

  initial begin
    int w;
    int n;

    bus.rx_valid   = 1'b0;
    bus.rx_data    = 8'h00;
    bus.rx_sof     = 1'b0;
    bus.tx_ready   = 1'b0;
    bus.status_reg = 32'h0;

    tick();
    tick();
    chk_reset("rst");
    rst_n = 1'b1;
    tick();

    // Single write, then a second write offered while the hold is still running.
    write3(8'h10, 8'h0A, 8'hBC);
    chk("w1_wr_reg", {20'b0, bus.wr_reg}, 32'h0ABC);
    chk("w1_addr", {28'b0, bus.wr_reg_addr}, 32'd0);
    chk("w1_changed", {31'b0, bus.wr_reg_changed}, 32'd1);
    chk("w1_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
    send_byte(8'h11, 1'b1, w);
    chk("w2_stall", w, H + 1);
    chk("w1_stable", {20'b0, bus.wr_reg}, 32'h0ABC);
    send_byte(8'h00, 1'b0, w);
    send_byte(8'h03, 1'b0, w);
    chk("w2_wr_reg", {20'b0, bus.wr_reg}, 32'h0003);
    chk("w2_addr", {28'b0, bus.wr_reg_addr}, 32'd1);
    chk("w2_changed", {31'b0, bus.wr_reg_changed}, 32'd0);
    n = 0;
    while (!bus.rx_ready && n < 50) begin
      tick();
      n++;
    end
    chk("w2_hold_len", n, H);
    chk("w2_stable", {20'b0, bus.wr_reg}, 32'h0003);

    // Status read with a mid-response change of status_reg.
    bus.status_reg = 32'h12345678;
    send_byte(8'h20, 1'b1, w);
    chk("rd_tx_valid", {31'b0, bus.tx_valid}, 32'd1);
    chk("rd_first", {24'b0, bus.tx_data}, 32'h12);
    chk("rd_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
    bus.status_reg = 32'hDEADBEEF;
    recv4(32'h12345678);

    // Partial write aborted by SOF on a status command.
    send_byte(8'h10, 1'b0, w);
    send_byte(8'h05, 1'b0, w);
    send_byte(8'h20, 1'b1, w);
    chk("ab_err_cnt", {24'b0, bus.err_cnt}, 32'd1);
    chk("ab_changed", {31'b0, bus.wr_reg_changed}, 32'd0);
    chk("ab_wr_reg", {20'b0, bus.wr_reg}, 32'h0003);
    recv4(32'hDEADBEEF);

    for (int i = 0; i < 300; i++) begin
      send_byte(8'hF0, 1'b0, w);
    end
    chk("bad_err_sat", {24'b0, bus.err_cnt}, 32'd255);
    chk("bad_wr_reg", {20'b0, bus.wr_reg}, 32'h0003);
    chk("bad_changed", {31'b0, bus.wr_reg_changed}, 32'd0);
    chk("bad_rx_ready", {31'b0, bus.rx_ready}, 32'd1);

    // Reset with toggle at 1 and a response in flight.
    write3(8'h10, 8'h01, 8'h23);
    chk("w3_wr_reg", {20'b0, bus.wr_reg}, 32'h0123);
    chk("w3_changed", {31'b0, bus.wr_reg_changed}, 32'd1);
    bus.status_reg = 32'hCAFEF00D;
    send_byte(8'h20, 1'b1, w);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    chk("mid_tx_data", {24'b0, bus.tx_data}, 32'hFE);
    rst_n = 1'b0;
    tick();
    chk_reset("mid_rst");
    rst_n = 1'b1;
    tick();
    write3(8'h11, 8'h0F, 8'hFF);
    chk("w4_wr_reg", {20'b0, bus.wr_reg}, 32'h0FFF);
    chk("w4_addr", {28'b0, bus.wr_reg_addr}, 32'd1);
    chk("w4_changed", {31'b0, bus.wr_reg_changed}, 32'd1);
    chk("w4_err_cnt", {24'b0, bus.err_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
